// File: rtl/branch_pkg.sv
// Shared types, opcode constants and immediate extractors for the branch resolve unit.
// No ports; imported by bht_2bit and branch_resolve_unit.
package branch_pkg;

    typedef enum logic [2:0] {
        BEQ,
        BNE,
        BLT,
        BGE,
        BLTU,
        BGEU,
        BR_NOP
    } br_cmp_t;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Weakly not-taken.
    localparam logic [1:0] BHT_INIT = 2'b01;

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    // funct3 values 2 and 3 have no compare and map to BR_NOP.
    function automatic br_cmp_t decode_cmp(input logic [2:0] funct3);
        unique case (funct3)
            3'd0:    return BEQ;
            3'd1:    return BNE;
            3'd4:    return BLT;
            3'd5:    return BGE;
            3'd6:    return BLTU;
            3'd7:    return BGEU;
            default: return BR_NOP;
        endcase
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Handshake and data bundle of the branch resolve unit.
// master: producer/consumer side (drives instruction, operands, flush, out_ready).
// slave:  the unit (drives in_ready and all out_* results).
interface branch_resolve_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction_code;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_is_branch;
    logic            out_illegal;
    logic            out_pred_taken;
    logic            out_taken;
    logic            out_redirect;
    logic [XLEN-1:0] out_target;
    logic [XLEN-1:0] out_link;

    modport master (
        output flush, in_valid, instruction_code, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, out_is_branch, out_illegal, out_pred_taken, out_taken,
               out_redirect, out_target, out_link
    );

    modport slave (
        input  flush, in_valid, instruction_code, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, out_is_branch, out_illegal, out_pred_taken, out_taken,
               out_redirect, out_target, out_link
    );
endinterface

// File: rtl/bht_2bit.sv
// Array of 2-bit saturating direction counters.
// Ports: clk/reset (sync, active-high, all counters -> BHT_INIT), rd_idx/rd_ctr (combinational
// read), wr_en/wr_idx/wr_inc (single update port: increment if wr_inc else decrement).
module bht_2bit
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_inc
);
    logic [1:0] ctr_q [DEPTH];
    logic [1:0] wr_cur;
    logic [1:0] wr_nxt;

    assign rd_ctr = ctr_q[rd_idx];
    assign wr_cur = ctr_q[wr_idx];

    always_comb begin
        wr_nxt = wr_cur;
        if (wr_inc) begin
            if (wr_cur != 2'b11) wr_nxt = wr_cur + 2'd1;
        end else begin
            if (wr_cur != 2'b00) wr_nxt = wr_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) ctr_q[i] <= BHT_INIT;
        end else if (wr_en) begin
            ctr_q[wr_idx] <= wr_nxt;
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Branch decode-and-resolve stage feeding the fetch redirect path.
// Ports: clk, reset (sync, active-high), bus (branch_resolve_unit_if.slave): input instruction,
// pc and operands with in_valid/in_ready and flush; one registered result with
// out_valid/out_ready carrying branch kind, prediction, resolved direction, target and link.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned BHT_DEPTH     = 16,
    parameter bit          SUPPORT_JUMPS = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    branch_resolve_unit_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    br_cmp_t         cmp;
    logic            is_cond, is_jal, is_jalr, is_branch, illegal;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic            eq, lt_s, lt_u, cond_taken, taken, pred;
    logic [XLEN-1:0] target, link;
    logic [IDX_W-1:0] bht_idx;
    logic [1:0]      bht_ctr;
    logic            in_ready, accept;

    logic            valid_q, is_branch_q, illegal_q, pred_q, taken_q;
    logic [XLEN-1:0] target_q, link_q;

    assign opcode  = bus.instruction_code[6:0];
    assign funct3  = bus.instruction_code[14:12];
    assign cmp     = decode_cmp(funct3);
    assign is_cond = (opcode == OPC_BRANCH);
    assign is_jal  = SUPPORT_JUMPS && (opcode == OPC_JAL);
    assign is_jalr = SUPPORT_JUMPS && (opcode == OPC_JALR) && (funct3 == 3'd0);
    assign is_branch = is_cond || is_jal || is_jalr;
    assign illegal = is_cond && (cmp == BR_NOP);

    always_comb begin
        imm32 = imm_b(bus.instruction_code);
        if (is_jal)  imm32 = imm_j(bus.instruction_code);
        if (is_jalr) imm32 = imm_i(bus.instruction_code);
    end
    // Size cast of a signed operand sign-extends to XLEN.
    assign imm = XLEN'($signed(imm32));

    assign eq   = (bus.rs1_data == bus.rs2_data);
    assign lt_s = ($signed(bus.rs1_data) < $signed(bus.rs2_data));
    assign lt_u = (bus.rs1_data < bus.rs2_data);

    always_comb begin
        cond_taken = 1'b0;
        unique case (cmp)
            BEQ:     cond_taken = eq;
            BNE:     cond_taken = !eq;
            BLT:     cond_taken = lt_s;
            BGE:     cond_taken = !lt_s;
            BLTU:    cond_taken = lt_u;
            BGEU:    cond_taken = !lt_u;
            default: cond_taken = 1'b0;
        endcase
    end

    assign bht_idx = bus.pc[IDX_W+1:2];
    // Jumps never consult the table; non-branches predict nothing.
    assign pred  = is_cond ? bht_ctr[1] : 1'b0;
    assign taken = is_cond ? cond_taken : (is_jal || is_jalr);
    assign link  = bus.pc + XLEN'(4);

    always_comb begin
        target = '0;
        if (is_cond || is_jal) target = bus.pc + imm;
        if (is_jalr)           target = (bus.rs1_data + imm) & {{(XLEN-1){1'b1}}, 1'b0};
    end

    assign in_ready = !valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready && !bus.flush;

    bht_2bit #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk    (clk),
        .reset  (reset),
        .rd_idx (bht_idx),
        .rd_ctr (bht_ctr),
        .wr_en  (accept && is_cond && !illegal),
        .wr_idx (bht_idx),
        .wr_inc (cond_taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            is_branch_q <= 1'b0;
            illegal_q   <= 1'b0;
            pred_q      <= 1'b0;
            taken_q     <= 1'b0;
            target_q    <= '0;
            link_q      <= '0;
        end else if (accept) begin
            valid_q     <= 1'b1;
            is_branch_q <= is_branch;
            illegal_q   <= illegal;
            pred_q      <= pred;
            taken_q     <= taken;
            target_q    <= target;
            link_q      <= link;
        end else if (bus.flush || bus.out_ready) begin
            valid_q     <= 1'b0;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = valid_q;
    assign bus.out_is_branch  = is_branch_q;
    assign bus.out_illegal    = illegal_q;
    assign bus.out_pred_taken = pred_q;
    assign bus.out_taken      = taken_q;
    assign bus.out_redirect   = taken_q ^ pred_q;
    assign bus.out_target     = target_q;
    assign bus.out_link       = link_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
    import branch_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(32)) b0 ();
    branch_resolve_unit_if #(.XLEN(32)) b1 ();

    // Second instance without jump decode sees identical stimulus.
    assign b1.flush            = b0.flush;
    assign b1.in_valid         = b0.in_valid;
    assign b1.instruction_code = b0.instruction_code;
    assign b1.pc               = b0.pc;
    assign b1.rs1_data         = b0.rs1_data;
    assign b1.rs2_data         = b0.rs2_data;
    assign b1.out_ready        = b0.out_ready;

    branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(16), .SUPPORT_JUMPS(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(16), .SUPPORT_JUMPS(1'b0)) dut_nj (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input int imm);
        logic [12:0] b;
        b = imm[12:0];
        return {b[12], b[10:5], 5'd2, 5'd1, f3, b[4:1], b[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_jalr(input int imm);
        logic [11:0] i;
        i = imm[11:0];
        return {i, 5'd1, 3'b000, 5'd1, OPC_JALR};
    endfunction

    function automatic logic [31:0] enc_jal(input int imm);
        logic [20:0] j;
        j = imm[20:0];
        return {j[20], j[10:1], j[11], j[19:12], 5'd1, OPC_JAL};
    endfunction

    task automatic present(input logic [31:0] ins, input logic [31:0] p,
                           input logic [31:0] r1, input logic [31:0] r2);
        b0.in_valid = 1'b1;
        b0.instruction_code = ins;
        b0.pc = p;
        b0.rs1_data = r1;
        b0.rs2_data = r2;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] r1, input logic [31:0] r2);
        present(ins, p, r1, r2);
        @(posedge clk);
        #1;
        b0.in_valid = 1'b0;
    endtask

    initial begin
        b0.flush = 1'b0;
        b0.in_valid = 1'b0;
        b0.out_ready = 1'b1;
        b0.instruction_code = 32'h0000_0013;
        b0.pc = '0;
        b0.rs1_data = '0;
        b0.rs2_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("reset_valid", b0.out_valid, 1'b0);
        chk("reset_target", b0.out_target, 32'h0);
        chk("reset_in_ready", b0.in_ready, 1'b1);

        // BEQ equal operands, imm +16, index 0 at 01
        send(enc_b(3'd0, 16), 32'h100, 32'd5, 32'd5);
        chk("beq1_valid", b0.out_valid, 1'b1);
        chk("beq1_isbr", b0.out_is_branch, 1'b1);
        chk("beq1_taken", b0.out_taken, 1'b1);
        chk("beq1_pred", b0.out_pred_taken, 1'b0);
        chk("beq1_redir", b0.out_redirect, 1'b1);
        chk("beq1_target", b0.out_target, 32'h110);
        chk("beq1_link", b0.out_link, 32'h104);
        send(enc_b(3'd0, 16), 32'h100, 32'd5, 32'd5);
        chk("beq2_pred", b0.out_pred_taken, 1'b1);
        chk("beq2_redir", b0.out_redirect, 1'b0);

        send(enc_b(3'd4, -8), 32'h204, 32'hFFFF_FFFF, 32'd1);
        chk("blt_taken", b0.out_taken, 1'b1);
        chk("blt_target", b0.out_target, 32'h1FC);
        send(enc_b(3'd6, 16), 32'h208, 32'hFFFF_FFFF, 32'd1);
        chk("bltu_taken", b0.out_taken, 1'b0);
        chk("bltu_redir", b0.out_redirect, 1'b0);
        send(enc_b(3'd7, 16), 32'h20C, 32'd0, 32'd0);
        chk("bgeu_taken", b0.out_taken, 1'b1);

        send(enc_jalr(6), 32'h300, 32'h2001, 32'd0);
        chk("jalr_target", b0.out_target, 32'h2006);
        chk("jalr_taken", b0.out_taken, 1'b1);
        chk("jalr_pred", b0.out_pred_taken, 1'b0);
        chk("jalr_redir", b0.out_redirect, 1'b1);
        chk("jalr_link", b0.out_link, 32'h304);
        chk("nj_valid", b1.out_valid, 1'b1);
        chk("nj_isbr", b1.out_is_branch, 1'b0);
        chk("nj_taken", b1.out_taken, 1'b0);
        chk("nj_target", b1.out_target, 32'h0);

        send(enc_jal(-4), 32'h400, 32'd0, 32'd0);
        chk("jal_target", b0.out_target, 32'h3FC);
        chk("jal_redir", b0.out_redirect, 1'b1);

        // Backpressure: A held for 3 cycles while B waits
        send(enc_b(3'd1, 32), 32'h210, 32'd1, 32'd2);
        b0.out_ready = 1'b0;
        present(enc_b(3'd0, 4), 32'h214, 32'd1, 32'd2);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", b0.in_ready, 1'b0);
            chk("bp_valid", b0.out_valid, 1'b1);
            chk("bp_target", b0.out_target, 32'h230);
        end
        b0.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", b0.in_ready, 1'b1);
        @(posedge clk);
        #1;
        b0.in_valid = 1'b0;
        chk("bp_b_valid", b0.out_valid, 1'b1);
        chk("bp_b_target", b0.out_target, 32'h218);
        chk("bp_b_taken", b0.out_taken, 1'b0);
        @(posedge clk);
        #1;
        chk("drain_valid", b0.out_valid, 1'b0);

        // Flush drops a taken branch at index 6 with no table update
        present(enc_b(3'd0, 16), 32'h218, 32'd1, 32'd1);
        b0.flush = 1'b1;
        #1;
        chk("flush_in_ready", b0.in_ready, 1'b1);
        @(posedge clk);
        #1;
        b0.flush = 1'b0;
        b0.in_valid = 1'b0;
        chk("flush_valid", b0.out_valid, 1'b0);
        send(enc_b(3'd0, 16), 32'h218, 32'd1, 32'd1);
        chk("flush_pred0", b0.out_pred_taken, 1'b0);
        send(enc_b(3'd0, 16), 32'h218, 32'd1, 32'd1);
        chk("flush_pred1", b0.out_pred_taken, 1'b1);

        // Illegal funct3 leaves index 7 at 01
        send(enc_b(3'd2, 16), 32'h21C, 32'd1, 32'd1);
        chk("ill_flag", b0.out_illegal, 1'b1);
        chk("ill_taken", b0.out_taken, 1'b0);
        send(enc_b(3'd0, 16), 32'h21C, 32'd1, 32'd1);
        chk("ill_pred0", b0.out_pred_taken, 1'b0);
        chk("ill_clear", b0.out_illegal, 1'b0);
        send(enc_b(3'd0, 16), 32'h21C, 32'd1, 32'd1);
        chk("ill_pred1", b0.out_pred_taken, 1'b1);

        // Ten taken then not-taken at index 8: saturates at 3, then 3->2->1
        for (int k = 0; k < 10; k++) begin
            send(enc_b(3'd0, 16), 32'h220, 32'd7, 32'd7);
            chk("sat_pred", b0.out_pred_taken, (k == 0) ? 1'b0 : 1'b1);
        end
        send(enc_b(3'd1, 16), 32'h220, 32'd7, 32'd7);
        chk("nt1_pred", b0.out_pred_taken, 1'b1);
        chk("nt1_taken", b0.out_taken, 1'b0);
        chk("nt1_redir", b0.out_redirect, 1'b1);
        send(enc_b(3'd1, 16), 32'h220, 32'd7, 32'd7);
        chk("nt2_pred", b0.out_pred_taken, 1'b1);
        send(enc_b(3'd1, 16), 32'h220, 32'd7, 32'd7);
        chk("nt3_pred", b0.out_pred_taken, 1'b0);

        // Reset during a stall drops the held result and reinitialises the table
        send(enc_b(3'd0, 16), 32'h100, 32'd5, 32'd5);
        chk("pre_rst_pred", b0.out_pred_taken, 1'b1);
        b0.out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        b0.out_ready = 1'b1;
        chk("rst_stall_valid", b0.out_valid, 1'b0);
        chk("rst_stall_pred", b0.out_pred_taken, 1'b0);
        chk("rst_stall_target", b0.out_target, 32'h0);
        send(enc_b(3'd0, 16), 32'h100, 32'd5, 32'd5);
        chk("post_rst_pred", b0.out_pred_taken, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
